// File: rtl/sprite_compositor.sv
// Multi-sprite overlay: keyed, index-priority sprites composited over a background pixel stream.
// Optional per-slot collision flags are built when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
  parameter int          N_SPR    = 4,
  parameter int          W        = 32,
  parameter int          H        = 32,
  parameter int          ROM_LAT  = 1,
  parameter logic [11:0] KEY      = 12'hFFF,
  parameter logic [9:0]  V_COMMIT = 10'd480
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bright,
  input  logic [9:0]                  hCount,
  input  logic [9:0]                  vCount,
  input  logic [11:0]                 background,
  input  logic                        wr_en,
  input  logic [2:0]                  wr_sel,
  input  logic [9:0]                  wr_x,
  input  logic [9:0]                  wr_y,
  input  logic                        wr_vis,
  output logic [N_SPR*$clog2(H)-1:0]  rom_row,
  output logic [N_SPR*$clog2(W)-1:0]  rom_col,
  input  logic [N_SPR*12-1:0]         rom_data,
  output logic [11:0]                 rgb,
  output logic                        frame_commit,
  output logic [N_SPR-1:0]            coll_flags
);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);
  localparam int DEPTH = ROM_LAT + 1;

  logic             w_commit;
  logic [N_SPR-1:0] w_hit;

  assign w_commit = (vCount == V_COMMIT) && (hCount == 10'd0);

  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_slot
    logic [9:0]    r_sh_x, r_sh_y, r_x, r_y;
    logic          r_sh_vis, r_vis;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_in_x, w_in_y;

    // Shadow takes host writes; active reloads only at the frame boundary.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sh_x   <= '0;
        r_sh_y   <= '0;
        r_sh_vis <= 1'b0;
        r_x      <= '0;
        r_y      <= '0;
        r_vis    <= 1'b0;
      end else begin
        if (wr_en && (wr_sel == 3'(gi))) begin
          r_sh_x   <= wr_x;
          r_sh_y   <= wr_y;
          r_sh_vis <= wr_vis;
        end
        if (w_commit) begin
          r_x   <= r_sh_x;
          r_y   <= r_sh_y;
          r_vis <= r_sh_vis;
        end
      end
    end

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    assign w_in_x = ({1'b0, hCount} >= {1'b0, r_x}) &&
                    ({1'b0, hCount} <  ({1'b0, r_x} + 11'(W)));
    assign w_in_y = ({1'b0, vCount} >= {1'b0, r_y}) &&
                    ({1'b0, vCount} <  ({1'b0, r_y} + 11'(H)));
    assign w_hit[gi] = r_vis && bright && w_in_x && w_in_y;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_row <= '0;
        r_col <= '0;
      end else begin
        r_row <= vCount[RW-1:0] - r_y[RW-1:0];
        r_col <= hCount[CW-1:0] - r_x[CW-1:0];
      end
    end

    assign rom_row[gi*RW +: RW] = r_row;
    assign rom_col[gi*CW +: CW] = r_col;
  end

  logic [N_SPR-1:0] r_hit_d [DEPTH];
  logic [11:0]      r_bg_d  [DEPTH];
  logic [DEPTH-1:0] r_bright_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_hit_d[i] <= '0;
        r_bg_d[i]  <= '0;
      end
      r_bright_d <= '0;
    end else begin
      r_hit_d[0]    <= w_hit;
      r_bg_d[0]     <= background;
      r_bright_d[0] <= bright;
      for (int i = 1; i < DEPTH; i++) begin
        r_hit_d[i]    <= r_hit_d[i-1];
        r_bg_d[i]     <= r_bg_d[i-1];
        r_bright_d[i] <= r_bright_d[i-1];
      end
    end
  end

  logic [N_SPR-1:0] w_opaque;
  logic [11:0]      w_pix;

  // Walk from the highest slot down so the lowest opaque index wins.
  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < N_SPR; i++) begin
      w_opaque[i] = r_hit_d[DEPTH-1][i] && (rom_data[i*12 +: 12] != KEY);
    end
    w_pix = r_bg_d[DEPTH-1];
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_pix = rom_data[i*12 +: 12];
    end
    if (!r_bright_d[DEPTH-1]) w_pix = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb          <= '0;
      frame_commit <= 1'b0;
    end else begin
      rgb          <= w_pix;
      frame_commit <= w_commit;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] r_acc;
  logic [N_SPR-1:0] w_multi;

  assign w_multi = ((w_opaque & (w_opaque - N_SPR'(1))) != '0) ? w_opaque : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      coll_flags <= '0;
    end else if (w_commit) begin
      coll_flags <= r_acc;
      r_acc      <= w_multi;
    end else begin
      r_acc <= r_acc | w_multi;
    end
  end
`else
  assign coll_flags = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels, per-slot ROM model, latency-aligned monitor.
module tb_sprite_compositor;
  localparam int N   = 4;
  localparam int RW  = 5;
  localparam int CW  = 5;
  localparam int LAT = 1;
`ifdef SPRITE_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            bright;
  logic [9:0]      hCount, vCount;
  logic [11:0]     background;
  logic            wr_en;
  logic [2:0]      wr_sel;
  logic [9:0]      wr_x, wr_y;
  logic            wr_vis;
  logic [N*RW-1:0] rom_row;
  logic [N*CW-1:0] rom_col;
  logic [N*12-1:0] rom_data;
  logic [11:0]     rgb;
  logic            frame_commit;
  logic [N-1:0]    coll_flags;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPR(N), .W(32), .H(32), .ROM_LAT(LAT), .KEY(12'hFFF), .V_COMMIT(10'd480)) dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .background(background), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
    .wr_vis(wr_vis), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .rgb(rgb), .frame_commit(frame_commit), .coll_flags(coll_flags)
  );

  // ROM model: colour = {slot+1, row[3:0], col[3:0]}, or the key when masked.
  logic [N-1:0]    key_mask;
  logic [N*12-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) rom_pipe[k] <= rom_pipe[k-1];
    for (int s = 0; s < N; s++) begin
      rom_pipe[0][s*12 +: 12] <= key_mask[s] ? 12'hFFF :
        {4'(s + 1), rom_row[s*RW +: 4], rom_col[s*CW +: 4]};
    end
  end
  assign rom_data = rom_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    int          kind;
    logic [11:0] exp;
  } exp_t;
  exp_t  q[$];
  string qn[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Monitor: each entry is due at its stamp cycle; kind 0 rgb, 1 frame_commit, 2 coll_flags.
  exp_t        m_e;
  string       m_nm;
  logic [11:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      m_e  = q.pop_front();
      m_nm = qn.pop_front();
      case (m_e.kind)
        0:       m_act = rgb;
        1:       m_act = {11'b0, frame_commit};
        default: m_act = {8'b0, coll_flags};
      endcase
      n_tests++;
      if (m_e.stamp != cyc || m_act !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, required %h (cycle %0d, due %0d)", m_nm, m_act, m_e.exp, cyc, m_e.stamp);
      end else begin
        $display("ok   %s: %h", m_nm, m_act);
      end
    end
  end

  task automatic push(input int st, input int k, input logic [11:0] e, input string nm);
    exp_t x;
    x.stamp = st;
    x.kind  = k;
    x.exp   = e;
    q.push_back(x);
    qn.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic b, input logic [11:0] bg);
    hCount = h;
    vCount = v;
    bright = b;
    background = bg;
  endtask

  task automatic idle;
    drive(10'd700, 10'd600, 1'b0, 12'h000);
    step;
  endtask

  task automatic drain;
    repeat (LAT + 3) idle;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b,
                     input logic [11:0] bg, input logic [11:0] e, input string nm);
    drive(h, v, b, bg);
    push(cyc + LAT + 2, 0, e, nm);
    step;
  endtask

  task automatic wr(input logic [2:0] s, input logic [9:0] x, input logic [9:0] y, input logic v);
    drive(10'd700, 10'd600, 1'b0, 12'h000);
    wr_en = 1'b1; wr_sel = s; wr_x = x; wr_y = y; wr_vis = v;
    step;
    wr_en = 1'b0;
  endtask

  // Commit pixel; optionally also writes slot0 x=wx in the same cycle.
  task automatic commit(input logic [3:0] e_coll, input bit wr_too, input logic [9:0] wx, input string nm);
    drain;
    drive(10'd0, 10'd480, 1'b0, 12'h000);
    if (wr_too) begin
      wr_en = 1'b1; wr_sel = 3'd0; wr_x = wx; wr_y = 10'd50; wr_vis = 1'b1;
    end
    push(cyc + 1, 1, 12'h001, {nm, " frame_commit"});
    push(cyc + 1, 2, {8'b0, e_coll}, {nm, " coll_flags"});
    step;
    wr_en = 1'b0;
    drive(10'd700, 10'd600, 1'b0, 12'h000);
    push(cyc + 1, 1, 12'h000, {nm, " pulse ends"});
    step;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; key_mask = '0;
    wr_en = 1'b0; wr_sel = '0; wr_x = '0; wr_y = '0; wr_vis = 1'b0;
    drive(10'd700, 10'd600, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset rgb", {20'b0, rgb}, 32'h0);
    chk("reset frame_commit", {31'b0, frame_commit}, 32'h0);
    chk("reset coll_flags", {28'b0, coll_flags}, 32'h0);
    chk("reset rom_row", {12'b0, rom_row}, 32'h0);
    chk("reset rom_col", {12'b0, rom_col}, 32'h0);
    rst = 1'b1;
    step;

    // Basic placement and edges.
    wr(3'd0, 10'd100, 10'd50, 1'b1);
    commit(4'b0000, 1'b0, 10'd0, "commit1");
    pix(10'd100, 10'd50, 1'b1, 12'h0A5, 12'h100, "s0 origin");
    pix(10'd99,  10'd50, 1'b1, 12'h0A5, 12'h0A5, "left of s0");
    pix(10'd131, 10'd50, 1'b1, 12'h0A6, 12'h10F, "s0 right col");
    pix(10'd132, 10'd50, 1'b1, 12'h0A7, 12'h0A7, "past right");
    pix(10'd101, 10'd53, 1'b1, 12'h000, 12'h131, "s0 r3c1");
    pix(10'd100, 10'd81, 1'b1, 12'h000, 12'h1F0, "s0 bottom row");
    pix(10'd100, 10'd82, 1'b1, 12'h0B0, 12'h0B0, "below s0");
    pix(10'd100, 10'd49, 1'b1, 12'h0B1, 12'h0B1, "above s0");

    // Double buffering, including a write landing in the commit cycle.
    wr(3'd0, 10'd200, 10'd50, 1'b1);
    pix(10'd100, 10'd50, 1'b1, 12'h0C0, 12'h100, "old pos holds");
    pix(10'd200, 10'd50, 1'b1, 12'h0C1, 12'h0C1, "new pos pending");
    commit(4'b0000, 1'b1, 10'd300, "commit2");
    pix(10'd200, 10'd50, 1'b1, 12'h0C2, 12'h100, "new pos live");
    pix(10'd100, 10'd50, 1'b1, 12'h0C3, 12'h0C3, "old pos gone");
    pix(10'd300, 10'd50, 1'b1, 12'h0C4, 12'h0C4, "commit-cycle write pending");
    commit(4'b0000, 1'b0, 10'd0, "commit3");
    pix(10'd300, 10'd50, 1'b1, 12'h0C5, 12'h100, "commit-cycle write live");

    // Priority and colour key.
    wr(3'd0, 10'd300, 10'd50, 1'b0);
    wr(3'd1, 10'd400, 10'd100, 1'b1);
    wr(3'd2, 10'd400, 10'd100, 1'b1);
    commit(4'b0000, 1'b0, 10'd0, "commit4");
    pix(10'd400, 10'd100, 1'b1, 12'h0D0, 12'h200, "s1 over s2");
    drain;
    key_mask = 4'b0010;
    pix(10'd400, 10'd100, 1'b1, 12'h0D1, 12'h300, "s1 keyed shows s2");
    drain;
    key_mask = 4'b0110;
    pix(10'd400, 10'd100, 1'b1, 12'h0D2, 12'h0D2, "both keyed bg");
    drain;
    key_mask = 4'b0000;

    // Right-edge clipping and blanking.
    wr(3'd3, 10'd1010, 10'd200, 1'b1);
    commit(COLL ? 4'b0110 : 4'b0000, 1'b0, 10'd0, "commit5");
    pix(10'd1010, 10'd200, 1'b1, 12'h0E0, 12'h400, "s3 at 1010");
    pix(10'd1023, 10'd200, 1'b1, 12'h0E1, 12'h40D, "s3 col13");
    pix(10'd0,    10'd200, 1'b1, 12'h0E2, 12'h0E2, "no wrap h0");
    pix(10'd5,    10'd200, 1'b1, 12'h0E3, 12'h0E3, "no wrap h5");
    pix(10'd9,    10'd200, 1'b1, 12'h0E4, 12'h0E4, "no wrap h9");
    pix(10'd1012, 10'd200, 1'b0, 12'h0E5, 12'h000, "bright low in sprite");

    // Collision accumulation across frames.
    wr(3'd0, 10'd600, 10'd300, 1'b1);
    wr(3'd3, 10'd600, 10'd300, 1'b1);
    commit(4'b0000, 1'b0, 10'd0, "commit6");
    pix(10'd600, 10'd300, 1'b1, 12'h0F0, 12'h100, "s0 over s3");
    commit(COLL ? 4'b1001 : 4'b0000, 1'b0, 10'd0, "commit7");
    commit(4'b0000, 1'b0, 10'd0, "commit8");

    // Asynchronous reset in the middle of visible sprites.
    drain;
    drive(10'd605, 10'd303, 1'b1, 12'h111);
    repeat (LAT + 3) step;
    chk("pre-reset rgb", {20'b0, rgb}, 32'h135);
    rst = 1'b0;
    #1;
    chk("mid-frame reset rgb", {20'b0, rgb}, 32'h0);
    chk("mid-frame reset rom_row", {12'b0, rom_row}, 32'h0);
    chk("mid-frame reset rom_col", {12'b0, rom_col}, 32'h0);
    chk("mid-frame reset frame_commit", {31'b0, frame_commit}, 32'h0);
    step;
    step;
    rst = 1'b1;
    pix(10'd605, 10'd303, 1'b1, 12'h111, 12'h111, "post-reset bg only");
    commit(4'b0000, 1'b0, 10'd0, "commit9");
    pix(10'd605, 10'd303, 1'b1, 12'h222, 12'h222, "post-reset commit still bg");
    pix(10'd0,   10'd0,   1'b1, 12'h333, 12'h333, "post-reset origin bg");

    for (int i = 0; i < 20 && q.size() > 0; i++) step;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
